bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq_pkg.sv | 17 +
 rtl/bin2bcd_seq_adj3.sv | 15 +
 rtl/bin2bcd_seq.sv | 101 ++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// parameter defaults, FSM state encoding and the bit-counter terminal value.
package bin2bcd_seq_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int NDIG_DEF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Counter value during the last of the eight SHIFT edges.
    localparam logic [2:0] CNT_LAST = 3'd7;

endpackage

// File: rtl/bin2bcd_seq_adj3.sv
// Double-dabble digit correction: adds 3 to a BCD nibble of 5 or more so that
// the following left shift carries correctly into the next decimal digit.
module bcd_adj3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Handshake: start_i is sampled only in IDLE; busy_o is high while in SHIFT; done_o pulses for one cycle when new digits appear.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NDIG  = NDIG_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] bin_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       bcd2_o,
    output logic [3:0]       bcd1_o,
    output logic [3:0]       bcd0_o,
    output logic [1:0]       state_o
);

    localparam int SW = 4 * NDIG;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [SW-1:0]    scr_q, scr_d;
    logic [SW-1:0]    scr_adj;
    logic [2:0]       cnt_q, cnt_d;
    logic [SW-1:0]    dig_q, dig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_adj3 u_adj (
            .digit_i (scr_q[4*g +: 4]),
            .digit_o (scr_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    sr_d    = bin_in_i;
                    scr_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Correct every nibble first, then shift the whole {scratch, binary} pair.
                {scr_d, sr_d} = {scr_adj, sr_q} << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CNT_LAST) begin
                    dig_d   = scr_d;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign bcd2_o  = dig_q[11:8];
    assign bcd1_o  = dig_q[7:4];
    assign bcd0_o  = dig_q[3:0];
    assign state_o = state_q;

endmodule
